// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: run-mode and controller-state encodings shared by the step/run controller and LCD formatter
package cpu_dbg_pkg;
  typedef enum logic [1:0] {MODE_STEP, MODE_RUN, MODE_BP, MODE_CNT} mode_t;
  typedef enum logic {ST_HALT, ST_RUN} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and one-cycle press pulse on debounced rise
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CCLK,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  always_ff @(posedge CCLK or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        level <= s2;
        press <= s2;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/step_run_ctrl.sv
// step_run_ctrl: single-clock step/run/breakpoint/run-N execution controller gating the datapath via cpu_en
module step_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int NBP        = 2,
  parameter int CNT_W      = 32,
  parameter int DEB_CYCLES = 500000,
  parameter int RUN_DIV    = 1,
  localparam int IDX_W     = NBP > 1 ? $clog2(NBP) : 1
) (
  input  logic                CCLK,
  input  logic                reset,
  input  logic                btn_step,
  input  logic                btn_run,
  input  logic [1:0]          mode,
  input  logic [NBP*PC_W-1:0] bp_addr,
  input  logic [NBP-1:0]      bp_en,
  input  logic [15:0]         run_count,
  input  logic [PC_W-1:0]     pc,
  input  logic                halt_req,
  output logic                cpu_en,
  output logic                running,
  output logic                bp_hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic [CNT_W-1:0]    instr_cnt
);
  localparam int DIV_W = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  state_t st;
  mode_t run_mode;
  logic step_press, run_press, step_go, first, run_pend, tick, stop_run, stop_bp, stop;
  logic [15:0] remain;
  logic [DIV_W-1:0] div;
  logic [NBP-1:0] bp_match;
  logic [IDX_W-1:0] bp_idx;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (.CCLK(CCLK), .reset(reset), .btn(btn_step), .press(step_press));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (.CCLK(CCLK), .reset(reset), .btn(btn_run), .press(run_press));
  for (genvar i = 0; i < NBP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc);
  end
  always_comb begin
    bp_idx = '0;
    for (int k = NBP - 1; k >= 0; k--) if (bp_match[k]) bp_idx = IDX_W'(k);
  end
  assign tick     = (st == ST_RUN) && (div == '0);
  assign stop_run = run_press || run_pend;
  assign stop_bp  = (run_mode == MODE_BP) && !first && (|bp_match);
  assign stop     = stop_run || halt_req || stop_bp || ((run_mode == MODE_CNT) && (remain == '0));
  assign cpu_en   = ((st == ST_HALT) && step_go) || (tick && !stop);
  assign running  = (st == ST_RUN);
  always_ff @(posedge CCLK or posedge reset)
    if (reset) begin
      st <= ST_HALT;
      run_mode <= MODE_STEP;
      step_go <= 1'b0;
      first <= 1'b0;
      run_pend <= 1'b0;
      remain <= '0;
      div <= '0;
      bp_hit <= 1'b0;
      hit_idx <= '0;
      instr_cnt <= '0;
    end else begin
      if (cpu_en) instr_cnt <= instr_cnt + 1'b1;
      step_go <= (st == ST_HALT) && step_press && !run_press;
      if (st == ST_HALT) begin
        run_pend <= 1'b0;
        div <= '0;
        if (run_press && (mode != MODE_STEP) && !((mode == MODE_CNT) && (run_count == '0))) begin
          st <= ST_RUN;
          run_mode <= mode_t'(mode);
          remain <= run_count;
          bp_hit <= 1'b0;
          first <= 1'b1;
        end
      end else begin
        div <= (div == DIV_W'(RUN_DIV - 1)) ? '0 : div + 1'b1;
        run_pend <= (run_pend || run_press) && !tick;
        if (tick) begin
          if (stop) st <= ST_HALT;
          // only a breakpoint that is the actual stop cause is reported
          if (stop_bp && !stop_run && !halt_req) begin
            bp_hit <= 1'b1;
            hit_idx <= bp_idx;
          end
          if (!stop) begin
            first <= 1'b0;
            if (run_mode == MODE_CNT) remain <= remain - 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_step_run_ctrl.sv
// tb_step_run_ctrl: directed table-driven bench plus hand sequences for breakpoints, divider, stops and reset
module tb_step_run_ctrl;
  localparam int DEB = 4;
  logic CCLK = 0, reset = 1;
  logic btn_step = 0, btn_run = 0, btn_step3 = 0, btn_run3 = 0, halt_req = 0;
  logic [1:0] mode = 0, bp_en = 0;
  logic [63:0] bp_addr = 0;
  logic [15:0] run_count = 0;
  logic [31:0] pc = 0;
  logic cpu_en, running, bp_hit, cpu_en3, running3, bp_hit3;
  logic [0:0] hit_idx, hit_idx3;
  logic [31:0] instr_cnt, instr_cnt3;
  int ncmp = 0, nerr = 0;
  int cyc = 0, pulses, consec, max_consec, halt_pulses, saw_run, total = 0;
  int p3 = 0, last3 = -1, gap_bad3 = 0, hr_pulses3 = 0;
  logic [31:0] first_pc;
  always #5 CCLK = ~CCLK;
  step_run_ctrl #(.PC_W(32), .NBP(2), .CNT_W(32), .DEB_CYCLES(DEB), .RUN_DIV(1)) u_dut (
    .CCLK(CCLK), .reset(reset), .btn_step(btn_step), .btn_run(btn_run), .mode(mode),
    .bp_addr(bp_addr), .bp_en(bp_en), .run_count(run_count), .pc(pc), .halt_req(halt_req),
    .cpu_en(cpu_en), .running(running), .bp_hit(bp_hit), .hit_idx(hit_idx), .instr_cnt(instr_cnt));
  step_run_ctrl #(.PC_W(32), .NBP(2), .CNT_W(32), .DEB_CYCLES(DEB), .RUN_DIV(3)) u_div3 (
    .CCLK(CCLK), .reset(reset), .btn_step(btn_step3), .btn_run(btn_run3), .mode(mode),
    .bp_addr(bp_addr), .bp_en(bp_en), .run_count(run_count), .pc(pc), .halt_req(halt_req),
    .cpu_en(cpu_en3), .running(running3), .bp_hit(bp_hit3), .hit_idx(hit_idx3), .instr_cnt(instr_cnt3));
  // datapath PC model: advances by one instruction on each commit
  always @(posedge CCLK) if (cpu_en) pc <= pc + 32'd4;
  always @(negedge CCLK) begin
    cyc++;
    if (cpu_en) begin
      if (pulses == 0) first_pc = pc;
      pulses++;
      consec++;
      total++;
      if (consec > max_consec) max_consec = consec;
      if (!running) halt_pulses++;
    end else consec = 0;
    if (running) saw_run = 1;
    if (cpu_en3) begin
      if (last3 >= 0 && cyc - last3 != 3) gap_bad3++;
      last3 = cyc;
      p3++;
      if (halt_req) hr_pulses3++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge CCLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clr();
    pulses = 0; consec = 0; max_consec = 0; halt_pulses = 0; saw_run = 0; first_pc = 0;
  endtask
  task automatic press(input bit s, input bit r);
    btn_step = s; btn_run = r;
    tick(10);
    btn_step = 0; btn_run = 0;
    tick(10);
  endtask
  typedef struct {
    string name; logic [1:0] md; logic [15:0] cnt; bit s; bit r; int exp_p; int exp_consec; bit exp_run;
  } vec_t;
  vec_t v[8];
  logic [31:0] base;
  int n;
  initial begin
    v[0] = '{"step_a", 2'd0, 16'd0, 1, 0, 1, 1, 0};
    v[1] = '{"step_b", 2'd0, 16'd0, 1, 0, 1, 1, 0};
    v[2] = '{"step_c", 2'd0, 16'd0, 1, 0, 1, 1, 0};
    v[3] = '{"run_m0", 2'd0, 16'd0, 0, 1, 0, 0, 0};
    v[4] = '{"run_n5", 2'd3, 16'd5, 0, 1, 5, 5, 1};
    v[5] = '{"run_n0", 2'd3, 16'd0, 0, 1, 0, 0, 0};
    v[6] = '{"run_n1", 2'd3, 16'd1, 0, 1, 1, 1, 1};
    v[7] = '{"step_m2", 2'd2, 16'd0, 1, 0, 1, 1, 0};
    clr();
    tick(3);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_running", running, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_hit_idx", hit_idx, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
    reset = 0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      mode = v[i].md; run_count = v[i].cnt;
      clr();
      base = instr_cnt;
      press(v[i].s, v[i].r);
      tick(10);
      chk({v[i].name, "_pulses"}, pulses, v[i].exp_p);
      chk({v[i].name, "_consec"}, max_consec, v[i].exp_consec);
      chk({v[i].name, "_saw_run"}, saw_run, v[i].exp_run);
      chk({v[i].name, "_running"}, running, 0);
      chk({v[i].name, "_cnt"}, instr_cnt - base, v[i].exp_p);
    end
    chk("table_instr_cnt", instr_cnt, 10);
    // run-to-breakpoint on disabled bp0 at 0 and enabled bp1 at 0x10
    mode = 2; bp_addr = {32'h10, 32'h0}; bp_en = 2'b10; pc = 0;
    clr();
    press(0, 1);
    tick(5);
    chk("bp_pulses", pulses, 4);
    chk("bp_first_pc", first_pc, 0);
    chk("bp_stop_pc", pc, 32'h10);
    chk("bp_hit", bp_hit, 1);
    chk("bp_hit_idx", hit_idx, 1);
    chk("bp_running", running, 0);
    clr();
    btn_run = 1; tick(10); btn_run = 0; tick(2);
    chk("bp_resume_pc", first_pc, 32'h10);
    chk("bp_resume_clear", bp_hit, 0);
    chk("bp_resume_running", running, 1);
    tick(10);
    press(0, 1);
    tick(3);
    chk("bp_btn_stop_running", running, 0);
    chk("bp_btn_stop_hit", bp_hit, 0);
    // both breakpoints match: lowest index wins
    pc = 0; bp_addr = {32'h8, 32'h8}; bp_en = 2'b11;
    clr();
    press(0, 1);
    tick(5);
    chk("prio_pulses", pulses, 2);
    chk("prio_hit", bp_hit, 1);
    chk("prio_idx", hit_idx, 0);
    bp_en = 0;
    // free-run with divider 3, stopped by halt_req
    mode = 1;
    btn_run3 = 1; tick(10); btn_run3 = 0; tick(10);
    chk("div3_running", running3, 1);
    chk("div3_some_pulses", p3 >= 4, 1);
    halt_req = 1;
    for (int k = 0; k < 10 && running3; k++) tick(1);
    halt_req = 0;
    chk("div3_halt_running", running3, 0);
    chk("div3_halt_pulses", hr_pulses3, 0);
    chk("div3_cnt", instr_cnt3, p3);
    tick(5);
    // restart, then a run press mid-divide stops at the very next tick
    last3 = -1;
    btn_run3 = 1; tick(10); btn_run3 = 0; tick(7);
    chk("div3_rerun", running3, 1);
    btn_run3 = 1;
    n = 0;
    for (int k = 0; k < 20 && running3; k++) begin tick(1); n++; end
    btn_run3 = 0;
    tick(10);
    chk("div3_press_lat", n >= 7 && n <= 9, 1);
    chk("div3_gap", gap_bad3, 0);
    chk("div3_cnt2", instr_cnt3, p3);
    // simultaneous step and run in HALT: run wins
    mode = 1;
    clr();
    base = instr_cnt;
    btn_step = 1; btn_run = 1; tick(10); btn_step = 0; btn_run = 0; tick(10);
    chk("simul_running", running, 1);
    press(0, 1);
    tick(3);
    chk("simul_stopped", running, 0);
    chk("simul_halt_pulses", halt_pulses, 0);
    chk("simul_cnt", instr_cnt - base, pulses);
    chk("total_cnt", instr_cnt, total);
    // asynchronous reset mid free-run
    press(0, 1);
    chk("pre_rst_running", running, 1);
    chk("pre_rst_cpu_en", cpu_en, 1);
    #2 reset = 1;
    #1;
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_running", running, 0);
    chk("arst_instr_cnt", instr_cnt, 0);
    tick(2);
    reset = 0;
    clr();
    tick(15);
    chk("post_rst_running", running, 0);
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_cnt", instr_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/step_run_ctrl.md
# step_run_ctrl

Execution controller for the board-level MIPS CPU. It replaces the "debounced button is the PC clock" scheme with a single-clock design: the datapath runs on CCLK and advances only when `cpu_en` is high. The block debounces the step/run buttons and runs the CPU in one of four modes: single-step, free-run, run-to-breakpoint or run-N-instructions. It also keeps a retired-instruction counter and exports state for the LCD status line.

## Interface
Parameters:
- `PC_W`, 32, PC width compared against breakpoints.
- `NBP`, 2, number of breakpoint comparators (≥1).
- `CNT_W`, 32, instruction counter width.
- `DEB_CYCLES`, 500000, CCLK cycles a raw button must be stable to count as pressed or released (10 ms at 50 MHz).
- `RUN_DIV`, 1, CCLK cycles per run-mode tick (≥1; 1 = one instruction per cycle).

Ports:
- `CCLK` in 1: the single system clock.
- `reset` in 1: asynchronous, active-high.
- `btn_step` in 1: raw step button, asynchronous to CCLK.
- `btn_run` in 1: raw run/halt toggle button.
- `mode` in 2: 0 step, 1 free-run, 2 run-to-breakpoint, 3 run-N.
- `bp_addr` in NBP*PC_W: breakpoint i occupies bits [i*PC_W +: PC_W].
- `bp_en` in NBP: per-breakpoint enable.
- `run_count` in 16: N for mode 3.
- `pc` in PC_W: current datapath PC.
- `halt_req` in 1: decoded break/syscall at `pc`; level.
- `cpu_en` out 1: datapath commits PC, regfile and memory on this CCLK edge.
- `running` out 1: state is RUN.
- `bp_hit` out 1: sticky; set on a breakpoint stop, cleared at the next run start.
- `hit_idx` out $clog2(NBP) (min 1): lowest matching breakpoint index.
- `instr_cnt` out CNT_W: count of `cpu_en` pulses since reset.

## Operation
- Button path: 2-flop synchroniser, then a stability counter of DEB_CYCLES. A debounced rising edge produces a one-cycle `press` pulse.
- FSM has 2 states: HALT and RUN. Reset state is HALT.
- HALT:
  - A `step` press issues exactly one `cpu_en` pulse on the next cycle. It ignores breakpoints and `halt_req`.
  - A `run` press when `mode`=0 is ignored.
  - A `run` press with `mode`≠0: latch `mode` into `run_mode`, load `remain` ← `run_count`, clear `bp_hit`, set `first`=1, go to RUN.
  - A `run` press in mode 3 with `run_count`=0 does not enter RUN and issues no pulse.
- RUN:
  - A tick fires every RUN_DIV cycles. The divider is cleared on RUN entry, so the first tick is the cycle after entry.
  - On a tick, the stop conditions are evaluated in priority order:
    - `run` press → HALT.
    - `halt_req` → HALT.
    - `run_mode`=2, `first`=0, and any enabled `bp_addr`==`pc` → HALT, set `bp_hit`, `hit_idx`.
    - `run_mode`=3 and `remain`=0 → HALT.
  - If no stop condition holds, `cpu_en`=1, `first`←0, and `remain` decrements in mode 3.
  - `first` lets a run resume from the breakpoint it stopped on.
  - A `run` press between ticks is held pending and honoured at the next tick.
- `step` press while in RUN is ignored.
- A `step` press and a `run` press in the same cycle: `run` wins and `step` is dropped.
- `instr_cnt` increments on every `cpu_en`, in any state, and wraps at 2^CNT_W.
- `mode` changes while in RUN have no effect until the next run start.

## Timing
- Reset values: `cpu_en`=0, `running`=0, `bp_hit`=0, `hit_idx`=0, `instr_cnt`=0, debouncers released, `remain`=0.
- Button-to-action latency: 2 sync cycles + DEB_CYCLES + 1 cycle.
- `cpu_en` is a combinational function of registered state, tick, `pc`, `halt_req` and the breakpoint compare. The compare therefore always uses the `pc` of the instruction about to commit. No other output is combinational.
- With RUN_DIV=1, `cpu_en` may be high on consecutive cycles. Mode 3 then delivers exactly N pulses, and `running` falls the cycle after the (N+1)-th tick.
- `reset` asserted mid-run: immediate HALT, counters cleared, no further `cpu_en` pulse.

## Structure
- A shared package `cpu_dbg_pkg` holds:
  - the mode encoding (MODE_STEP, MODE_RUN, MODE_BP, MODE_CNT);
  - the state encoding (ST_HALT, ST_RUN), which the LCD formatter reuses.
- One sub-module `btn_debounce` (synchroniser + DEB_CYCLES stability counter + press pulse), instantiated twice.
- The breakpoint compare is a generate loop with a priority encoder for `hit_idx`.

## Test plan
Benches use DEB_CYCLES=4 for speed.
- Step: mode 0; press step 3 times → exactly 3 single-cycle `cpu_en` pulses, `instr_cnt`=3, `running`=0 throughout.
- Run-N: mode 3, run_count=5, RUN_DIV=1 → 5 consecutive `cpu_en` pulses, then `running`=0, `instr_cnt`=5. Repeat with run_count=0 → no pulse, never enters RUN.
- Breakpoint: mode 2, bp_en=2'b10, bp_addr[1]=0x10, pc model +4 per pulse from 0 → pulses at pc 0,4,8,0xC, halt with `bp_hit`=1, `hit_idx`=1. A second run press → first pulse at pc 0x10, `bp_hit` cleared.
- Stop causes: free-run with RUN_DIV=3 → pulses every 3rd cycle. Assert `halt_req` → no pulse that tick, HALT. Repeat, pressing run mid-divide → HALT at the next tick.
- Simultaneous presses: step and run in the same cycle in HALT, mode 1 → enters RUN, and no extra step pulse is counted.
- Reset mid-run: assert reset during free-run → `cpu_en`, `running`, `instr_cnt` all 0 within the same cycle (asynchronous), and the block stays in HALT after release.
